// File: rtl/aes_pkg.sv
// Shared AES-128 definitions: round count, Rcon table, S-box and datapath types.
package aes_pkg;

   localparam int AES_ROUNDS = 10;

   typedef logic [127:0] state_t;
   typedef logic [31:0]  word_t;
   typedef logic [3:0]   round_t;

   localparam round_t LAST_ROUND = round_t'(AES_ROUNDS);

   localparam logic [7:0] RCON [1:AES_ROUNDS] = '{
      8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36
   };

   localparam logic [7:0] SBOX [256] = '{
      8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
      8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
      8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
      8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
      8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
      8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
      8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
      8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
      8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
      8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
      8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
      8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
      8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
      8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
      8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
      8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
   };

   function automatic logic [7:0] sbox(input logic [7:0] b);
      return SBOX[b];
   endfunction

   // Indices outside 1..10 only occur on paths whose result is discarded.
   function automatic logic [7:0] rcon(input round_t i);
      if (i >= 4'd1 && i <= LAST_ROUND) return RCON[i];
      return 8'h00;
   endfunction

endpackage

// File: rtl/add_round_key_if.sv
// Data/control bundle between the mixColumns stage and the AddRoundKey stage.
interface add_round_key_if;
   import aes_pkg::*;

   logic   key_load;
   state_t key;
   logic   en;
   state_t state;
   state_t state_out;
   logic   done;
   round_t round;
   logic   last_round;

   modport master (
      output key_load, key, en, state,
      input  state_out, done, round, last_round
   );

   modport slave (
      input  key_load, key, en, state,
      output state_out, done, round, last_round
   );

endinterface

// File: rtl/key_expand_step.sv
// One AES-128 key-schedule step: round key i-1 in, round key i out (purely combinational).
module key_expand_step
   import aes_pkg::*;
(
   input  state_t rk_i,
   input  round_t round_i,
   output state_t rk_o
);

   word_t w3;
   word_t rot;
   word_t t;
   word_t n0, n1, n2, n3;

   // NOTE: every variable is assigned on every pass, so no latches are inferred.
   always_comb begin
      w3  = rk_i[127:96];
      rot = {w3[7:0], w3[31:8]};
      for (int b = 0; b < 4; b++) begin
         t[8*b +: 8] = sbox(rot[8*b +: 8]);
      end
      t  = t ^ {24'h0, rcon(round_i)};
      n0 = rk_i[31:0]   ^ t;
      n1 = rk_i[63:32]  ^ n0;
      n2 = rk_i[95:64]  ^ n1;
      n3 = rk_i[127:96] ^ n2;
      rk_o = {n3, n2, n1, n0};
   end

endmodule

// File: rtl/add_round_key.sv
// AddRoundKey stage with on-the-fly key schedule and round counter.
// Define AES_KEY_RELOAD_EN to keep a cipher-key copy and restart the schedule after round 10.
module add_round_key
   import aes_pkg::*;
(
   input logic           clk,
   input logic           rst,
   add_round_key_if.slave bus
);

   state_t rk_q, rk_d, rk_next;
   round_t rc_q, rc_d, rc_inc;
   state_t state_out_q, state_out_d;
   logic   done_q, done_d;
   round_t round_q, round_d;
   logic   last_round_q, last_round_d;
   logic   halted;
   logic   accept;

`ifdef AES_KEY_RELOAD_EN
   state_t ck_q, ck_d;
   assign halted = 1'b0;
`else
   logic halted_q, halted_d;
   assign halted = halted_q;
`endif

   assign rc_inc = rc_q + 4'd1;
   assign accept = bus.en && !bus.key_load && !halted;

   key_expand_step u_step (
      .rk_i    (rk_q),
      .round_i (rc_inc),
      .rk_o    (rk_next)
   );

   always_comb begin
      rk_d         = rk_q;
      rc_d         = rc_q;
      state_out_d  = state_out_q;
      done_d       = 1'b0;
      round_d      = round_q;
      last_round_d = 1'b0;
`ifdef AES_KEY_RELOAD_EN
      ck_d         = ck_q;
`else
      halted_d     = halted_q;
`endif
      // A key load wins over a simultaneous accept; that state is dropped.
      if (bus.key_load) begin
         rk_d = bus.key;
         rc_d = '0;
`ifdef AES_KEY_RELOAD_EN
         ck_d = bus.key;
`else
         halted_d = 1'b0;
`endif
      end else if (accept) begin
         state_out_d  = bus.state ^ rk_q;
         round_d      = rc_q;
         done_d       = 1'b1;
         last_round_d = (rc_q == LAST_ROUND);
         if (rc_q == LAST_ROUND) begin
`ifdef AES_KEY_RELOAD_EN
            rk_d = ck_q;
            rc_d = '0;
`else
            halted_d = 1'b1;
`endif
         end else begin
            rk_d = rk_next;
            rc_d = rc_inc;
         end
      end
   end

   // NOTE: sequential state uses non-blocking assignments so all flops update together.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rk_q         <= '0;
         rc_q         <= '0;
         state_out_q  <= '0;
         done_q       <= 1'b0;
         round_q      <= '0;
         last_round_q <= 1'b0;
`ifdef AES_KEY_RELOAD_EN
         ck_q         <= '0;
`else
         halted_q     <= 1'b0;
`endif
      end else begin
         rk_q         <= rk_d;
         rc_q         <= rc_d;
         state_out_q  <= state_out_d;
         done_q       <= done_d;
         round_q      <= round_d;
         last_round_q <= last_round_d;
`ifdef AES_KEY_RELOAD_EN
         ck_q         <= ck_d;
`else
         halted_q     <= halted_d;
`endif
      end
   end

   assign bus.state_out  = state_out_q;
   assign bus.done       = done_q;
   assign bus.round      = round_q;
   assign bus.last_round = last_round_q;

endmodule

// File: tb/tb_add_round_key.sv
// Self-checking bench for add_round_key: FIPS-197 vector table, async reset, random vs model.
module tb_add_round_key;

   typedef logic [127:0] rk_arr_t [0:10];

   typedef struct {
      logic         kl;
      logic [127:0] key;
      logic         en;
      logic [127:0] st;
      logic         exp_done;
      logic [127:0] exp_so;
      logic [3:0]   exp_round;
      logic         exp_last;
   } vec_t;

   logic clk = 1'b0;
   logic rst = 1'b0;
   int   n_checks = 0;
   int   n_fail   = 0;

   logic [7:0] sbox_ref [256];
   vec_t       vecs [$];

   add_round_key_if bus ();

   add_round_key dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic check_outputs(input string tag, input logic d, input logic [127:0] so,
                                input logic [3:0] r, input logic l);
      check({tag, ".done"},       128'(bus.done),       128'(d));
      check({tag, ".state_out"},  bus.state_out,        so);
      check({tag, ".round"},      128'(bus.round),      128'(r));
      check({tag, ".last_round"}, 128'(bus.last_round), 128'(l));
   endtask

   // GF(2^8) arithmetic used to derive the S-box from first principles.
   function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p = 8'h00;
      for (int i = 0; i < 8; i++) begin
         if (b[0]) p ^= a;
         a = a[7] ? ((a << 1) ^ 8'h1b) : (a << 1);
         b = b >> 1;
      end
      return p;
   endfunction

   function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
      return (b << n) | (b >> (8 - n));
   endfunction

   task automatic build_sbox();
      for (int x = 0; x < 256; x++) begin
         logic [7:0] inv = 8'h00;
         for (int y = 1; y < 256; y++) begin
            if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
         end
         sbox_ref[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
      end
   endtask

   // Full FIPS-197 word-wise expansion into all eleven round keys.
   task automatic expand(input logic [127:0] k, output rk_arr_t rks);
      logic [31:0] w [44];
      logic [31:0] t;
      logic [7:0]  rc = 8'h01;
      for (int i = 0; i < 4; i++) w[i] = k[32*i +: 32];
      for (int i = 4; i < 44; i++) begin
         t = w[i-1];
         if (i % 4 == 0) begin
            t = {t[7:0], t[31:8]};
            for (int b = 0; b < 4; b++) t[8*b +: 8] = sbox_ref[t[8*b +: 8]];
            t[7:0] ^= rc;
            rc = gmul(rc, 8'h02);
         end
         w[i] = w[i-4] ^ t;
      end
      for (int r = 0; r <= 10; r++) rks[r] = {w[4*r+3], w[4*r+2], w[4*r+1], w[4*r]};
   endtask

   // FIPS-197 hex strings list byte 0 first; the bus puts byte 0 at bits [7:0].
   function automatic logic [127:0] fips(input logic [127:0] v);
      logic [127:0] o;
      for (int i = 0; i < 16; i++) o[8*i +: 8] = v[127 - 8*i -: 8];
      return o;
   endfunction

   function automatic vec_t mk(input logic kl, input logic [127:0] key, input logic en,
                               input logic [127:0] st, input logic d, input logic [127:0] so,
                               input logic [3:0] r, input logic l);
      vec_t v;
      v.kl = kl; v.key = key; v.en = en; v.st = st;
      v.exp_done = d; v.exp_so = so; v.exp_round = r; v.exp_last = l;
      return v;
   endfunction

   task automatic drive(input logic kl, input logic [127:0] key, input logic en, input logic [127:0] st);
      bus.key_load = kl;
      bus.key      = key;
      bus.en       = en;
      bus.state    = st;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      logic [127:0] k, k2, p, c0, r1, r10, x, last_so;
      logic [3:0]   last_r;
      rk_arr_t      sched_k;
      rk_arr_t      m_sched;
      int           m_rc;
      logic         m_halted;
      logic [127:0] m_so;
      logic         m_done;
      logic [3:0]   m_round;

      drive(1'b0, '0, 1'b0, '0);
      build_sbox();
      #1;
      check_outputs("reset", 1'b0, '0, 4'd0, 1'b0);
      repeat (2) @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      #1;

      k   = fips(128'h2b7e151628aed2a6abf7158809cf4f3c);
      p   = fips(128'h3243f6a8885a308d313198a2e0370734);
      c0  = fips(128'h193de3bea0f4e22b9ac68d2ae9f84808);
      r1  = fips(128'ha0fafe1788542cb123a339392a6c7605);
      r10 = fips(128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
      k2  = fips(128'h000102030405060708090a0b0c0d0e0f);
      x   = {$urandom, $urandom, $urandom, $urandom};
      expand(k, sched_k);

      vecs.push_back(mk(1'b0, '0, 1'b1, p,   1'b1, p,  4'd0, 1'b0));
      vecs.push_back(mk(1'b1, k,  1'b0, '0,  1'b0, p,  4'd0, 1'b0));
      vecs.push_back(mk(1'b0, '0, 1'b1, p,   1'b1, c0, 4'd0, 1'b0));
      vecs.push_back(mk(1'b1, k,  1'b0, '0,  1'b0, c0, 4'd0, 1'b0));
      for (int r = 0; r <= 10; r++) begin
         vecs.push_back(mk(1'b0, '0, 1'b1, '0, 1'b1,
                           (r == 0) ? k : (r == 1) ? r1 : (r == 10) ? r10 : sched_k[r],
                           4'(r), r == 10));
      end
`ifdef AES_KEY_RELOAD_EN
      vecs.push_back(mk(1'b0, '0, 1'b1, '0, 1'b1, k, 4'd0, 1'b0));
      last_so = k;   last_r = 4'd0;
`else
      vecs.push_back(mk(1'b0, '0, 1'b1, '0, 1'b0, r10, 4'd10, 1'b0));
      last_so = r10; last_r = 4'd10;
`endif
      vecs.push_back(mk(1'b1, k2, 1'b1, x,  1'b0, last_so, last_r, 1'b0));
      vecs.push_back(mk(1'b0, '0, 1'b1, x,  1'b1, x ^ k2,  4'd0,   1'b0));
      vecs.push_back(mk(1'b0, '0, 1'b0, '0, 1'b0, x ^ k2,  4'd0,   1'b0));

      foreach (vecs[i]) begin
         drive(vecs[i].kl, vecs[i].key, vecs[i].en, vecs[i].st);
         tick();
         check_outputs($sformatf("vec%0d", i), vecs[i].exp_done, vecs[i].exp_so,
                       vecs[i].exp_round, vecs[i].exp_last);
      end

      // Asynchronous reset landing mid-schedule, between clock edges.
      drive(1'b1, k, 1'b0, '0);
      tick();
      for (int r = 0; r <= 5; r++) begin
         drive(1'b0, '0, 1'b1, '0);
         tick();
      end
      check_outputs("pre_rst_r5", 1'b1, sched_k[5], 4'd5, 1'b0);
      drive(1'b0, '0, 1'b0, '0);
      #2 rst = 1'b0;
      #1;
      check_outputs("async_rst", 1'b0, '0, 4'd0, 1'b0);
      @(negedge clk);
      rst = 1'b1;
      drive(1'b0, '0, 1'b1, p);
      tick();
      check_outputs("post_rst_en", 1'b1, p, 4'd0, 1'b0);

      // Random traffic against a schedule-table model of the block.
      drive(1'b0, '0, 1'b0, '0);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      expand('0, m_sched);
      m_rc = 0; m_halted = 1'b0; m_so = '0; m_done = 1'b0; m_round = 4'd0;
      for (int cyc = 0; cyc < 400; cyc++) begin
         logic         kl, en;
         logic [127:0] key, st;
         kl  = ($urandom_range(0, 15) == 0);
         en  = ($urandom_range(0, 3) != 0);
         key = {$urandom, $urandom, $urandom, $urandom};
         st  = {$urandom, $urandom, $urandom, $urandom};
         drive(kl, key, en, st);
         if (kl) begin
            expand(key, m_sched);
            m_rc = 0; m_halted = 1'b0; m_done = 1'b0;
         end else if (en && !m_halted) begin
            m_so    = st ^ m_sched[m_rc];
            m_round = 4'(m_rc);
            m_done  = 1'b1;
            if (m_rc == 10) begin
`ifdef AES_KEY_RELOAD_EN
               m_rc = 0;
`else
               m_halted = 1'b1;
`endif
            end else begin
               m_rc++;
            end
         end else begin
            m_done = 1'b0;
         end
         tick();
         check_outputs($sformatf("rand%0d", cyc), m_done, m_so, m_round,
                       m_done && (m_round == 4'd10));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/add_round_key.md
# add_round_key

Pipelined AddRoundKey stage with an on-the-fly key schedule, placed directly downstream of the mixColumns stage in the iterative AES-128 encryption datapath. Each accepted state is XORed with the current round key and registered. The next round key is then derived in place from the stored key. A round counter tracks rounds 0..10 and signals the final round.

## Interface
- No parameters. Round count and Rcon come from the shared package.
- clk  in  1  rising-edge clock
- rst  in  1  reset, asynchronous, active-low (asserted when 0)
- key_load  in  1  load cipher key; restarts the schedule at round 0
- key  in  128  cipher key; byte i at bits [8i +: 8], word c at [32c +: 32]
- en  in  1  accept `state` this cycle
- state  in  128  column-major state; byte (row r, col c) at [8r+32c +: 8]
- state_out  out  128  registered state XOR round key
- done  out  1  one-cycle pulse: `state_out` updated
- round  out  4  round index of the key applied to the last output, 0..10
- last_round  out  1  `round` == 10 and `done`

## Operation
- Registers:
  - `rk`: current round key, 128 bits.
  - `rc`: next round to apply, 0..10.
  - `state_out`.
  - `done`.
  - `round`.
  - `ck`: cipher-key copy; present only with the macro, see Configuration.
- Key load: `key_load`=1 sets `rk`←`key`, `rc`←0, `ck`←`key`, `done`←0. `state_out` and `round` hold.
- Accept: `en`=1 with `key_load`=0 (and the block not halted). On that edge:
  - `state_out`←`state` ^ `rk`.
  - `round`←`rc`.
  - `done`←1.
  - `rk`←next(`rk`, `rc`+1).
  - `rc`←`rc`+1.
- Idle: `en`=0 gives `done`←0; all other registers hold.
- Key schedule next(w, i), with w0..w3 the words of w:
  - t = SubWord(RotWord(w3)) ^ {24'h0, Rcon[i]}.
  - RotWord(x) = {x[7:0], x[31:8]}.
  - Rcon[i] XORs bits [7:0] of t.
  - n0 = w0 ^ t, n1 = w1 ^ n0, n2 = w2 ^ n1, n3 = w3 ^ n2.
  - Rcon[1..10] = 01 02 04 08 10 20 40 80 1b 36.
- Wrap after round 10 (`rc`==10 at the accepting edge):
  - With the macro: `rk`←`ck`, `rc`←0.
  - Without the macro: the block halts, see Configuration.
- Simultaneous `key_load` and `en`: `key_load` wins. The state is dropped and `done`=0.
- Before the first `key_load` after reset: `rk`=0, so `state_out` = `state`.

## Timing
- Reset values: `state_out`=0, `done`=0, `round`=0, `rk`=0, `rc`=0, `ck`=0.
- Reset mid-operation clears everything immediately. No partial-round state survives.
- Latency: 1 cycle. `en` at edge N gives `state_out` and `done` valid after edge N.
- Throughput: one state per cycle, back-to-back.
- `done` is high for exactly one cycle per accepted state.
- The key schedule is one combinational step (4 S-box lookups) from `rk` to the `rk` D-input and must close timing in one cycle.
- No back-pressure: the downstream stage must consume `state_out` on the `done` cycle.

## Configuration
- Macro: `AES_KEY_RELOAD_EN`.
- Defined:
  - The `ck` register is instantiated.
  - After round 10, `rk` and `rc` return to the cipher key and 0 with no bubble.
  - Consecutive blocks under the same key need no reload.
- Undefined:
  - No `ck` register.
  - After round 10 is accepted the block halts: `en` is ignored and `done` stays 0.
  - The halt lasts until the next `key_load`.

## Structure
- Shared package `aes_pkg`:
  - `AES_ROUNDS`=10.
  - Rcon table as a localparam array indexed 1..10.
  - 128-bit `state_t` and 32-bit `word_t` typedefs.
  - S-box function.
- Sub-module `key_expand_step`: combinational, takes (`rk`, round index) and produces the next round key. It holds 4 S-box instances plus the XOR chain.
- Top level holds the counter, the registers and the wrap/halt logic.

## Test plan
All vectors are in FIPS-197 byte order, with byte 0 at bits [7:0].
- Reset, then `en` with `state`=3243f6a8885a308d313198a2e0370734 and no key load. Expect `state_out` equal to `state`, `done` pulse, `round`=0.
- `key_load` with 2b7e151628aed2a6abf7158809cf4f3c, then `en` with 3243f6a8885a308d313198a2e0370734. Expect `state_out`=193de3bea0f4e22b9ac68d2ae9f84808, `round`=0.
- After that load, 11 consecutive `en` cycles with `state`=0:
  - Outputs are the round keys; the round-1 output is a0fafe1788542cb123a339392a6c7605.
  - The round-10 output is d014f9a8c9ee2589e13f0cc8b6630ca6, with `last_round`=1.
- Twelfth `en`:
  - With the macro: output 2b7e151628aed2a6abf7158809cf4f3c, `round`=0.
  - Without the macro: no `done`, and `state_out` holds.
- `key_load` and `en` in the same cycle. Expect `done`=0, `rc`=0, and the next `en` applies the new key.
- Assert `rst`=0 asynchronously mid-schedule at round 5. Expect all outputs 0 immediately, with no clock edge needed.
